// File: rtl/i2c_target.sv
// I2C target (slave) with a fixed 7-bit address.
// Bus inputs are synchronized to `clock`; every bus event is derived from the synchronized copies.
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   scl_in, sda_in     raw bus levels (asynchronous)
//   sda_oe             1 = pull SDA low, 0 = release
//   rx_data, rx_valid  last written byte and its one-cycle strobe
//   tx_data, tx_req    byte to return on a read, and the request strobe for it
//   busy               high while this target is addressed
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h42
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRx, StRxAck, StTx, StTxAck, StIgnore
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       sda_oe_q, sda_oe_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       busy_q, busy_d;
  logic       rw_q, rw_d;

  // Two synchronizer stages plus one history stage per bus line.
  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_in;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_in;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  logic       scl_rise, scl_fall, start_det, stop_det, load_tx;
  logic [7:0] shift_in;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  // SCL must be high in both samples so an SDA edge coinciding with an SCL edge is not a condition.
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign shift_in  = {shift_q[6:0], sda_s2_q};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    sda_oe_d   = sda_oe_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy_q;
    rw_d       = rw_q;
    load_tx    = 1'b0;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        StIdle, StIgnore: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        StAddr: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              rw_d      = sda_s2_q;
              if (shift_in[7:1] == TARGET_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StAddrAck, StRxAck: begin
          // sda_oe_q doubles as the phase flag: low before the ACK slot, high during it.
          if (scl_rise && sda_oe_q && (state_q == StAddrAck) && rw_q) begin
            tx_req_d = 1'b1;
          end
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if ((state_q == StAddrAck) && rw_q) begin
                load_tx = 1'b1;
              end else begin
                state_d = StRx;
              end
            end
          end
        end
        StRx: begin
          if (scl_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d  = 4'd0;
              rx_data_d  = shift_in;
              rx_valid_d = 1'b1;
              state_d    = StRxAck;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StTx: begin
          // bit_cnt_q counts bits already placed on the bus.
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = StTxAck;
            end else begin
              sda_oe_d  = ~shift_q[7];
              shift_d   = {shift_q[6:0], 1'b0};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        StTxAck: begin
          if (scl_rise && (bit_cnt_q == 4'd0)) begin
            if (!sda_s2_q) begin
              tx_req_d  = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              state_d  = StIgnore;
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
            load_tx = 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase

      // First data bit goes out on the same fall that latches the byte.
      if (load_tx) begin
        shift_d   = {tx_data[6:0], 1'b0};
        sda_oe_d  = ~tx_data[7];
        bit_cnt_d = 4'd1;
        state_d   = StTx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      sda_oe_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      sda_oe_q   <= sda_oe_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_req   = tx_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged controller on a wired-AND bus, a transaction-level
// expectation model, a vector table, randomized transactions and directed corner cases.
module tb_i2c_target;

  localparam logic [6:0] Addr = 7'h42;
  localparam int Q = 6;  // clocks per quarter of an SCL bit

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       scl_in, sda_in, sda_oe, rx_valid, tx_req, busy;
  logic [7:0] rx_data;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  always #5 clock = ~clock;

  i2c_target #(.TARGET_ADDR(Addr)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .scl_in  (scl_in),
    .sda_in  (sda_in),
    .sda_oe  (sda_oe),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .busy    (busy)
  );

  // Free-running monitors; the stimulus takes before/after snapshots.
  int         rx_cnt = 0, txr_cnt = 0, oe_cnt = 0, dbl_cnt = 0;
  logic [7:0] rx_log [256];
  logic       rv_prev = 1'b0, tr_prev = 1'b0;

  always @(posedge clock) begin
    if (rx_valid) begin
      rx_log[rx_cnt % 256] <= rx_data;
      rx_cnt <= rx_cnt + 1;
    end
    if (tx_req) txr_cnt <= txr_cnt + 1;
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if ((rx_valid && rv_prev) || (tx_req && tr_prev)) dbl_cnt <= dbl_cnt + 1;
    rv_prev <= rx_valid;
    tr_prev <= tx_req;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bit_cycle(input logic drv, output logic seen);
    sda_m = drv;
    step(Q);
    scl_m = 1'b1;
    step(Q);
    seen = sda_in;
    step(Q);
    scl_m = 1'b0;
    step(Q);
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    step(Q);
    scl_m = 1'b1;
    step(Q);
    sda_m = 1'b0;
    step(Q);
    scl_m = 1'b0;
    step(Q);
  endtask

  task automatic i2c_stop;
    sda_m = 1'b0;
    step(Q);
    scl_m = 1'b1;
    step(Q);
    sda_m = 1'b1;
    step(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] d, input int k);
    return 8'(d >> (8 * (3 - k)));
  endfunction

  // One complete transaction; expectations come from the bus rules at transaction level:
  // a matching address is ACKed, writes are ACKed and delivered in order, reads return the
  // supplied bytes with one tx_req per byte, and everything else leaves the bus alone.
  task automatic xfer(input logic [7:0] ab, input int n, input logic [31:0] d,
                      input logic exp_ack);
    logic       ack, s, match, rw;
    logic [7:0] b;
    int         rx0, t0, o0;
    match = (ab[7:1] == Addr);
    rw    = ab[0];
    rx0 = rx_cnt;
    t0  = txr_cnt;
    o0  = oe_cnt;
    tx_data = byte_of(d, 0);
    i2c_start;
    send_byte(ab, ack);
    chk("addr_ack_bit", int'(ack), int'(!exp_ack));
    chk("busy_after_addr", int'(busy), int'(match));
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        send_byte(byte_of(d, k), ack);
        chk("write_ack_bit", int'(ack), int'(!match));
      end else begin
        for (int i = 7; i >= 0; i--) begin
          bit_cycle(1'b1, s);
          b[i] = s;
        end
        if (k < n - 1) tx_data = byte_of(d, k + 1);
        bit_cycle(k == n - 1, s);
        chk("read_byte", int'(b), match ? int'(byte_of(d, k)) : 32'hFF);
      end
    end
    if (rw && match) begin
      chk("oe_after_nack", int'(sda_oe), 0);
      chk("busy_after_nack", int'(busy), 0);
    end
    i2c_stop;
    step(Q);
    chk("rx_valid_count", rx_cnt - rx0, (match && !rw) ? n : 0);
    chk("tx_req_count", txr_cnt - t0, (match && rw) ? n : 0);
    chk("busy_after_stop", int'(busy), 0);
    if (!match) chk("oe_cycles_unaddressed", oe_cnt - o0, 0);
    if (match && !rw && (rx_cnt - rx0 == n)) begin
      for (int k = 0; k < n; k++)
        chk("rx_data_byte", int'(rx_log[(rx0 + k) % 256]), int'(byte_of(d, k)));
    end
  endtask

  typedef struct {
    logic [7:0]  ab;
    int          n;
    logic [31:0] d;
    logic        exp_ack;
  } vec_t;

  initial begin
    vec_t       vecs [7];
    logic       ack, s;
    logic [7:0] b;
    int         rx0, t0, o0, w;

    vecs[0] = '{8'h84, 1, 32'hA5000000, 1'b1};
    vecs[1] = '{8'h86, 1, 32'h11000000, 1'b0};
    vecs[2] = '{8'h85, 2, 32'h3CC30000, 1'b1};
    vecs[3] = '{8'h84, 3, 32'h00FF5A00, 1'b1};
    vecs[4] = '{8'h85, 1, 32'h81000000, 1'b1};
    vecs[5] = '{8'h00, 1, 32'h77000000, 1'b0};
    vecs[6] = '{8'h8D, 2, 32'h12340000, 1'b0};

    #1;
    chk("reset_sda_oe", int'(sda_oe), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_tx_req", int'(tx_req), 0);
    chk("reset_busy", int'(busy), 0);
    step(3);
    reset_n = 1'b1;
    step(4);

    for (int v = 0; v < 7; v++) xfer(vecs[v].ab, vecs[v].n, vecs[v].d, vecs[v].exp_ack);

    for (int r = 0; r < 14; r++) begin
      logic [6:0] a7;
      logic [7:0] ab;
      a7 = ($urandom_range(0, 1) == 1) ? Addr : 7'($urandom_range(0, 127));
      ab = {a7, 1'($urandom_range(0, 1))};
      xfer(ab, int'($urandom_range(1, 3)), $urandom, a7 == Addr);
    end

    // Repeated START after half a data byte, then a read.
    rx0 = rx_cnt;
    t0  = txr_cnt;
    tx_data = 8'h77;
    i2c_start;
    send_byte(8'h84, ack);
    chk("rs_write_addr_ack", int'(ack), 0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, s);
    i2c_start;
    send_byte(8'h85, ack);
    chk("rs_read_addr_ack", int'(ack), 0);
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(1'b1, s);
    chk("rs_read_byte", int'(b), 32'h77);
    i2c_stop;
    step(Q);
    chk("rs_no_rx_valid", rx_cnt - rx0, 0);
    chk("rs_tx_req_count", txr_cnt - t0, 1);

    // STOP in the middle of a data byte.
    rx0 = rx_cnt;
    i2c_start;
    send_byte(8'h84, ack);
    chk("ps_addr_ack", int'(ack), 0);
    for (int i = 0; i < 3; i++) bit_cycle(1'b0, s);
    i2c_stop;
    step(Q);
    chk("ps_no_rx_valid", rx_cnt - rx0, 0);
    chk("ps_busy", int'(busy), 0);
    xfer(8'h84, 1, 32'h3E000000, 1'b1);

    // Reset while the address ACK is being driven.
    i2c_start;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i] & 1'b0 | ((8'h84 >> i) & 8'h01) != 0, s);
    w = 0;
    while (sda_oe !== 1'b1 && w < 20) begin
      step(1);
      w++;
    end
    chk("mid_ack_oe_driven", int'(sda_oe), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_ack_reset_oe", int'(sda_oe), 0);
    chk("mid_ack_reset_rx_data", int'(rx_data), 0);
    chk("mid_ack_reset_busy", int'(busy), 0);
    step(3);
    reset_n = 1'b1;
    o0  = oe_cnt;
    rx0 = rx_cnt;
    send_byte(8'h84, ack);
    send_byte(8'hA5, ack);
    chk("post_reset_oe_cycles", oe_cnt - o0, 0);
    chk("post_reset_rx_valid", rx_cnt - rx0, 0);
    i2c_stop;
    step(Q);
    xfer(8'h84, 1, 32'h5A000000, 1'b1);

    chk("strobe_width", dbl_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
